// File: rtl/mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
// mem_bus_arbiter - round-robin memory-bus owner arbiter with burst cap and gap  | rev 1.0
// ============================================================================
module mem_bus_arbiter #(
  parameter int N_REQ      = 4,
  parameter int N_W        = 9,
  parameter int MAX_BURST  = 143,
  parameter int GAP_CYCLES = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ*N_W-1:0]     n_in,
  input  logic                     clear_timeout,
  output logic [N_REQ-1:0]         grant,
  output logic                     owner_valid,
  output logic [$clog2(N_REQ)-1:0] owner_id,
  output logic [N_W-1:0]           n_out,
  output logic [N_REQ-1:0]         timeout_flag
);

  localparam int ID_W  = $clog2(N_REQ);
  localparam int SUM_W = ID_W + 1;
  localparam int BC_W  = $clog2(MAX_BURST + 1);
  localparam int GC_W  = $clog2(GAP_CYCLES + 1);
  localparam logic [BC_W-1:0] BURST_LAST = BC_W'(MAX_BURST - 1);
  localparam logic [GC_W-1:0] GAP_LAST   = GC_W'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN  = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  state_t            state, state_nx;
  logic [ID_W-1:0]   ptr, ptr_nx, owner_nx, win, ptr_after;
  logic [SUM_W-1:0]  win_sum;
  logic              win_found;
  logic [N_REQ-1:0]  req_rot, grant_nx, flag_nx;
  logic [BC_W-1:0]   burst_cnt, burst_nx;
  logic [GC_W-1:0]   gap_cnt, gap_nx;
  logic [N_W-1:0]    n_nx;
  logic [N_W-1:0]    n_arr [N_REQ];

  for (genvar k = 0; k < N_REQ; k++) begin : g_nslice
    assign n_arr[k] = n_in[k*N_W +: N_W];
  end

  // Rotate requests so bit 0 is the current highest-priority requester.
  always_comb begin
    req_rot   = N_REQ'({req, req} >> ptr);
    win_found = 1'b0;
    win_sum   = '0;
    for (int j = N_REQ - 1; j >= 0; j--) begin
      if (req_rot[j]) begin
        win_found = 1'b1;
        win_sum   = SUM_W'(j) + {1'b0, ptr};
      end
    end
    win = (win_sum >= SUM_W'(N_REQ)) ? ID_W'(win_sum - SUM_W'(N_REQ)) : win_sum[ID_W-1:0];
  end

  assign ptr_after   = (owner_id == ID_W'(N_REQ - 1)) ? '0 : owner_id + ID_W'(1);
  assign owner_valid = |grant;

  always_comb begin
    state_nx = state;
    ptr_nx   = ptr;
    owner_nx = owner_id;
    n_nx     = n_out;
    grant_nx = grant;
    burst_nx = burst_cnt;
    gap_nx   = gap_cnt;
    flag_nx  = clear_timeout ? '0 : timeout_flag;
    case (state)
      ST_IDLE: begin
        if (win_found) begin
          state_nx = ST_OWN;
          grant_nx = N_REQ'(1) << win;
          owner_nx = win;
          n_nx     = n_arr[win];
          burst_nx = '0;
        end
      end
      ST_OWN: begin
        // A voluntary release takes precedence over the burst cap.
        if (!req[owner_id]) begin
          state_nx = ST_GAP;
          grant_nx = '0;
          ptr_nx   = ptr_after;
          gap_nx   = '0;
        end else if (burst_cnt == BURST_LAST) begin
          state_nx          = ST_GAP;
          grant_nx          = '0;
          ptr_nx            = ptr_after;
          gap_nx            = '0;
          flag_nx[owner_id] = 1'b1;
        end else begin
          burst_nx = burst_cnt + BC_W'(1);
        end
      end
      ST_GAP: begin
        if (gap_cnt == GAP_LAST) begin
          state_nx = ST_IDLE;
        end else begin
          gap_nx = gap_cnt + GC_W'(1);
        end
      end
      default: begin
        state_nx = ST_IDLE;
        grant_nx = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      ptr          <= '0;
      owner_id     <= '0;
      n_out        <= '0;
      grant        <= '0;
      burst_cnt    <= '0;
      gap_cnt      <= '0;
      timeout_flag <= '0;
    end else begin
      state        <= state_nx;
      ptr          <= ptr_nx;
      owner_id     <= owner_nx;
      n_out        <= n_nx;
      grant        <= grant_nx;
      burst_cnt    <= burst_nx;
      gap_cnt      <= gap_nx;
      timeout_flag <= flag_nx;
    end
  end

endmodule
`default_nettype wire
